// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR,
        LOAD,
        CHK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned WORD_BYTES = 4;

    // Clock cycles per UART bit, truncated.
    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, glitch reject,
// framing error on a low stop bit.
module uart_rx_byte #(
    parameter int unsigned DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int unsigned HALF  = (DIV / 2 > 0) ? DIV / 2 : 1;
    localparam int unsigned TMR_W = $clog2(DIV + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [TMR_W-1:0] timer;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state != RX_IDLE && timer != '0) begin
                timer <= timer - TMR_W'(1);
            end else begin
                case (state)
                    RX_IDLE: begin
                        if (rx_prev && !rx_sync) begin
                            state <= RX_START;
                            timer <= TMR_W'(HALF - 1);
                        end
                    end
                    // Mid start bit: a line already back high was only a glitch.
                    RX_START: begin
                        if (rx_sync) begin
                            state <= RX_IDLE;
                        end else begin
                            state   <= RX_DATA;
                            timer   <= TMR_W'(DIV - 1);
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        shreg   <= {rx_sync, shreg[7:1]};
                        timer   <= TMR_W'(DIV - 1);
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a little-endian program image (N, then N words) from UART into program memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte over the payload.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic [DATA_WIDTH-1:0] prog_data,
    output logic                  prog_we,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int unsigned DIV    = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned WORDS  = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned WORD_W = 8 * WORD_BYTES;

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              frame_err;

    loader_state_t     state;
    logic [1:0]        byte_cnt;
    logic [WORD_W-1:0] word_asm;
    logic [WORD_W-1:0] word_full;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  word_cnt_nx;
    logic [CNT_W-1:0]  n_words;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    uart_rx_byte #(.DIV(DIV)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    // Word as it stands once the current byte is shifted in (byte k lands in [8k+7:8k]).
    assign word_full   = {byte_data, word_asm[WORD_W-1:8]};
    assign word_cnt_nx = word_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HDR;
            byte_cnt  <= '0;
            word_asm  <= '0;
            word_cnt  <= '0;
            n_words   <= '0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_we   <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            prog_we <= 1'b0;
            if (frame_err && state != DONE) begin
                state <= ERROR;
                busy  <= 1'b1;
                err   <= 1'b1;
            end else if (byte_valid) begin
                case (state)
                    HDR: begin
                        word_asm <= word_full;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            word_cnt <= '0;
                            n_words  <= CNT_W'(word_full);
`ifdef LOADER_CHECKSUM_EN
                            csum     <= '0;
`endif
                            if (word_full > WORDS) begin
                                state <= ERROR;
                                err   <= 1'b1;
                            end else if (word_full == '0) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= CHK;
`else
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
`endif
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
                    LOAD: begin
                        word_asm <= word_full;
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ byte_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            prog_data <= word_full;
                            prog_addr <= word_cnt[ADDR_WIDTH-1:0];
                            prog_we   <= 1'b1;
                            word_cnt  <= word_cnt_nx;
                            if (word_cnt_nx == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= CHK;
`else
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CHK: begin
                        if (byte_data == csum) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: directed images, byte-level image model, per-cycle write checker.
`timescale 1ns/1ps
module tb_uart_program_loader;
    localparam int unsigned AW  = 10;
    localparam int          BIT = 10;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;
    logic          prog_we;
    logic          busy;
    logic          done;
    logic          err;

    uart_program_loader #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_we   (prog_we),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t           exp_q[$];
    logic [7:0]    img[$];
    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    int            bad_idx = -1;
    int            checks = 0;
    int            failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: busy mirrors !done, and each write matches the next expected (addr,data).
    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            check("busy_vs_done", busy, !done);
            if (prog_we) begin
                got_addr.push_back(prog_addr);
                got_data.push_back(prog_data);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", prog_we, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", prog_addr, e.addr);
                    check("wr_data", prog_data, e.data);
                end
            end
        end
    end

    // Walks the byte stream with the protocol rules; fills exp_q, returns final flags.
    task automatic model(output bit e_done, output bit e_err);
        logic [31:0] n;
        logic [31:0] w;
        logic [7:0]  x;
        int          pay_end;
        e_done = 0; e_err = 0; n = 0; w = 0; x = 0; pay_end = 0;
        exp_q.delete();
        for (int i = 0; i < img.size(); i++) begin
            if (e_done || e_err) break;
            if (i == bad_idx) begin
                e_err = 1;
                break;
            end
            if (i < 4) begin
                n[8*i +: 8] = img[i];
                if (i == 3) begin
                    pay_end = 4 + 4 * int'(n);
                    if (n > 1024) e_err = 1;
                    else if (n == 0 && !CK) e_done = 1;
                end
            end else if (i < pay_end) begin
                int k;
                k = (i - 4) % 4;
                w[8*k +: 8] = img[i];
                x = x ^ img[i];
                if (k == 3) begin
                    exp_q.push_back('{addr: AW'((i - 4) / 4), data: w});
                    if (i == pay_end - 1 && !CK) e_done = 1;
                end
            end else begin
                if (img[i] == x) e_done = 1;
                else e_err = 1;
            end
        end
    endtask

    task automatic hold(input logic v, input int cyc);
        rx = v;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        hold(1'b0, BIT);
        for (int j = 0; j < 8; j++) hold(b[j], BIT);
        hold(stop, BIT);
        hold(1'b1, 3);
    endtask

    task automatic run_image(input string name);
        bit ed, ee;
        model(ed, ee);
        for (int i = 0; i < img.size(); i++) send_byte(img[i], (i == bad_idx) ? 1'b0 : 1'b1);
        hold(1'b1, 20);
        check({name, "_done"}, done, ed);
        check({name, "_err"}, err, ee);
        check({name, "_busy"}, busy, !ed);
        check({name, "_writes_left"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hold(1'b1, 3);
        rst = 1'b0;
        bad_idx = -1;
        exp_q.delete();
        got_addr.delete();
        got_data.delete();
        hold(1'b1, 2);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_addr"}, prog_addr, 0);
        check({name, "_data"}, prog_data, 0);
        check({name, "_we"}, prog_we, 0);
        check({name, "_busy"}, busy, 1);
        check({name, "_done"}, done, 0);
        check({name, "_err"}, err, 0);
    endtask

    task automatic load_image_a();
        img = '{8'h02, 8'h00, 8'h00, 8'h00,
                8'h34, 8'h12, 8'h01, 8'h3C,
                8'h05, 8'h00, 8'h21, 8'h34};
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check_reset_values("reset");

        // Short low pulse in idle must not produce a byte.
        hold(1'b0, 3);
        hold(1'b1, 30);
        check("glitch_busy", busy, 1);
        check("glitch_done", done, 0);

        load_image_a();
        run_image("img_a");
        check("img_a_nwr", got_data.size(), 2);
        if (got_data.size() == 2) begin
            check("img_a_addr0", got_addr[0], 0);
            check("img_a_data0", got_data[0], 32'h3C011234);
            check("img_a_addr1", got_addr[1], 1);
            check("img_a_data1", got_data[1], 32'h34210005);
        end
        check("img_a_lit_done", done, 1);
        check("img_a_lit_busy", busy, 0);

        do_reset();
        img = '{8'h00, 8'h00, 8'h00, 8'h00};
        if (CK) img.push_back(8'h00);
        run_image("n0");
        check("n0_lit_done", done, 1);
        check("n0_nwr", got_data.size(), 0);

        do_reset();
        img = '{8'h01, 8'h04, 8'h00, 8'h00};
        run_image("n1025");
        check("n1025_lit_err", err, 1);
        check("n1025_lit_busy", busy, 1);
        check("n1025_nwr", got_data.size(), 0);

        do_reset();
        load_image_a();
        bad_idx = 5;
        run_image("badstop");
        check("badstop_lit_err", err, 1);
        check("badstop_nwr", got_data.size(), 0);

        do_reset();
        check_reset_values("rst_after_err");
        load_image_a();
        run_image("img_a_again");

        // Reset after 6 of 8 payload bytes; only the first word may be written.
        do_reset();
        load_image_a();
        void'(img.pop_back());
        void'(img.pop_back());
        run_image("partial");
        check("partial_nwr", got_data.size(), 1);
        do_reset();
        hold(1'b1, 50);
        check("partial_no_late_write", got_data.size(), 0);
        load_image_a();
        run_image("restart");

        do_reset();
        img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        if (CK) img.push_back(8'h44);
        run_image("ck_good");
        check("ck_good_lit_done", done, 1);

        if (CK) begin
            do_reset();
            img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h45};
            run_image("ck_bad");
            check("ck_bad_lit_err", err, 1);
            check("ck_bad_nwr", got_data.size(), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Serial-to-memory loader. Receives a program image on the board UART RX line, assembles 32-bit words, and writes them into the core's program memory through its write port.
- Holds the core in reset (busy) until the image is complete.
- Sits between the rx pin and the program memory's addr/DataIn/write inputs. It is the writer side of the program memory that the core only reads.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz
- BAUD, 115200, UART bit rate
- ADDR_WIDTH, 10, program memory word-address width (WORDS = 2**ADDR_WIDTH)
- DATA_WIDTH, 32, program memory word width; fixed at 32, other values unsupported

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx  in  1  UART receive line, asynchronous, idle high
- prog_addr  out  ADDR_WIDTH  program memory word address
- prog_data  out  32  word to write
- prog_we  out  1  one-cycle write strobe
- busy  out  1  high while loading; core held in reset while high
- done  out  1  sticky; image loaded successfully
- err  out  1  sticky; protocol or framing error

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: prog_addr=0, prog_data=0, prog_we=0, busy=1, done=0, err=0. FSM goes to HDR. Any partial byte or word is discarded. rst mid-load restarts the protocol from the header.
- rx passes through a 2-flop synchronizer before use; it is metastability-safe.
- Bit timing: DIV = CLK_FREQ/BAUD, integer-truncated.
- Byte receive flow:
  - A falling edge in idle starts a byte.
  - Wait DIV/2 cycles, then re-check rx. If rx is high, treat it as a glitch and return to idle with no byte.
  - Sample 8 data bits, LSB first, at DIV intervals, then sample the stop bit.
  - Stop bit = 0 is a framing error.
  - A byte_valid pulse is issued one cycle after the stop-bit sample.
- Protocol (all multi-byte fields little-endian):
  - 4-byte header N = word count, then N words of 4 bytes each.
- FSM states: HDR, LOAD, CHK (only with CHECKSUM_EN), DONE, ERROR.
- HDR:
  - Collects 4 bytes into N.
  - If N == 0: go to DONE.
  - If N > WORDS: go to ERROR.
  - Otherwise go to LOAD with word_cnt=0.
- LOAD:
  - Shift bytes into a 32-bit assembly register, byte k into bits [8k+7:8k].
  - On the 4th byte, in the next cycle: prog_data = word, prog_addr = word_cnt, prog_we = 1 for exactly one cycle. Then word_cnt increments.
  - When word_cnt reaches N, go to DONE (or CHK).
  - N == WORDS is legal; the last address written is WORDS-1, and the address counter does not wrap into a write.
- DONE: busy=0, done=1. Further rx bytes are ignored. Exit only via rst.
- ERROR: busy=1, err=1, prog_we never asserts. Exit only via rst.
- Framing error in any state other than DONE goes to ERROR.
- Write timing: prog_we asserts at most once per 4 byte times. Write latency is 1 cycle after the 4th byte_valid. prog_addr/prog_data are stable during the prog_we cycle.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the last word, FSM enters CHK and receives one byte.
  - That byte must equal the XOR of all 4N payload bytes; header bytes are excluded.
  - Match goes to DONE; mismatch goes to ERROR.
  - N == 0 still requires the checksum byte, which must be 0x00.
- Without the macro: no CHK state; DONE immediately follows the last write.

Decomposition:
- Shared package loader_pkg:
  - loader_state_t enum (HDR, LOAD, CHK, DONE, ERROR)
  - function baud_div(CLK_FREQ, BAUD)
  - localparam HDR_BYTES=4, WORD_BYTES=4
- Sub-module uart_rx_byte:
  - Contains the synchronizer, bit timer and bit counter.
  - Outputs byte_valid, byte_data[7:0], frame_err.
- Top level holds the protocol FSM, byte/word counters, assembly register and checksum.

Test Plan (CLK_FREQ=1000, BAUD=100, DIV=10):
- Header 02 00 00 00, words 0x3C011234 and 0x34210005 sent LE → two prog_we pulses: addr 0 data 0x3C011234, addr 1 data 0x34210005. Then busy=0, done=1, err=0.
- Header 00 00 00 00 → done=1, no prog_we (with LOADER_CHECKSUM_EN: after byte 00).
- Header with N=1025 (ADDR_WIDTH=10) → err=1, busy=1, no prog_we.
- Stop bit forced 0 on the 2nd payload byte → err=1, no write for that word; assert rst → all outputs at reset values, a fresh image loads correctly.
- rx low pulse of 3 cycles in idle → no byte_valid, FSM unchanged. Also assert rst after 6 of 8 payload bytes → no further writes, a restarted header is accepted.
- LOADER_CHECKSUM_EN, N=1, word 0x11223344, checksum 0x44:
  - 0x44 → done=1.
  - 0x45 → err=1; the word write at addr 0 still occurred.
